// File: rtl/mips_instr_encoder_pkg.sv
// Opcode constants, instruction word layouts and FSM encoding shared by the
// MIPS instruction encoder and the core's opcode decoder.
package mips_instr_encoder_pkg;

   localparam logic [5:0] OP_R_FORMAT = 6'd0;
   localparam logic [5:0] OP_J        = 6'd2;
   localparam logic [5:0] OP_JAL      = 6'd3;
   localparam logic [5:0] OP_BEQ      = 6'd4;
   localparam logic [5:0] OP_ADDIU    = 6'd9;
   localparam logic [5:0] OP_LW       = 6'd35;
   localparam logic [5:0] OP_SW       = 6'd43;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      FMT_R,
      FMT_I,
      FMT_J,
      FMT_NONE
   } fmt_t;

   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      logic [5:0] funct;
   } r_word_t;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] imm;
   } i_word_t;

   typedef struct packed {
      logic [5:0]  op;
      logic [25:0] target;
   } j_word_t;

   function automatic fmt_t op_format(input logic [5:0] op);
      fmt_t f;
      case (op)
         OP_R_FORMAT:                       f = FMT_R;
         OP_ADDIU, OP_LW, OP_SW, OP_BEQ:    f = FMT_I;
         OP_J, OP_JAL:                      f = FMT_J;
         default:                           f = FMT_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/mips_instr_encoder_instr_pack.sv
// Packs request fields into a 32-bit MIPS word and flags decodable opcodes.
// Combinational, zero latency; no flow control of its own.
// Backpressure: none, the caller decides when the result is used.
module mips_instr_encoder_instr_pack
   import mips_instr_encoder_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   r_word_t r_w;
   i_word_t i_w;
   j_word_t j_w;

   always_comb begin
      r_w   = '{op: op, rs: rs, rt: rt, rd: rd, shamt: shamt, funct: funct};
      i_w   = '{op: op, rs: rs, rt: rt, imm: imm};
      j_w   = '{op: op, target: target};
      word  = '0;
      legal = 1'b1;
      case (op_format(op))
         FMT_R:   word = r_w;
         FMT_I:   word = i_w;
         FMT_J:   word = j_w;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes one request per handshake and writes consecutive imem words.
// Latency: handshake in cycle N gives im_we in cycle N+1; count updates at end of N+1.
// Backpressure: req_ready low outside LOAD, during start, and once the final write is issued.
module mips_instr_encoder
   import mips_instr_encoder_pkg::*;
#(
   parameter int ADDR_W    = 6,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [5:0]        req_op,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_shamt,
   input  logic [5:0]        req_funct,
   input  logic [15:0]       req_imm,
   input  logic [25:0]       req_target,
   input  logic              req_last,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              overflow,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST    = BASE - PTR_ONE;
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic              ovf_q, ovf_d;
   logic              fin_q, fin_d;
   logic              fill_q, fill_d;
   logic [31:0]       pack_word;
   logic              pack_legal;
   logic              hs;

   mips_instr_encoder_instr_pack u_pack (
      .op     (req_op),
      .rs     (req_rs),
      .rt     (req_rt),
      .rd     (req_rd),
      .shamt  (req_shamt),
      .funct  (req_funct),
      .imm    (req_imm),
      .target (req_target),
      .word   (pack_word),
      .legal  (pack_legal)
   );

   // fin_q: the write in flight is the last of the load, so stop accepting now.
   assign req_ready = (state_q == ST_LOAD) && !start && !fin_q;
   assign hs        = req_valid && req_ready;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      count_d = count_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      err_d   = err_q;
      ovf_d   = ovf_q;
      fin_d   = fin_q;
      fill_d  = fill_q;

      if (we_q) begin
         count_d = count_q + CNT_ONE;
         if (fin_q) begin
            state_d = ST_DONE;
            fin_d   = 1'b0;
         end
         if (fill_q) begin
            ovf_d  = 1'b1;
            fill_d = 1'b0;
         end
      end

      if (hs) begin
         if (pack_legal) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = pack_word;
            ptr_d   = ptr_q + PTR_ONE;
            fin_d   = req_last || (ptr_q == LAST);
            fill_d  = !req_last && (ptr_q == LAST);
         end else begin
            err_d = 1'b1;
            if (req_last) begin
               state_d = ST_DONE;
            end
         end
      end

      // An in-flight write still lands (addr/wdata already registered), but its count is dropped.
      if (start) begin
         state_d = ST_LOAD;
         ptr_d   = BASE;
         count_d = '0;
         err_d   = 1'b0;
         ovf_d   = 1'b0;
         fin_d   = 1'b0;
         fill_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= BASE;
         addr_q  <= BASE;
         count_q <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         fin_q   <= 1'b0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         fin_q   <= fin_d;
         fill_q  <= fill_d;
      end
   end

   assign im_we    = we_q;
   assign im_addr  = addr_q;
   assign im_wdata = wdata_q;
   assign busy     = (state_q == ST_LOAD);
   assign done     = (state_q == ST_DONE);
   assign err      = err_q;
   assign overflow = ovf_q;
   assign count    = count_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: a 4-word memory based at word 1,
// so the fill wraps through address 0 before overflowing.
module tb_mips_instr_encoder;

   localparam int ADDR_W    = 2;
   localparam int BASE_ADDR = 1;
   localparam int DEPTH     = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              req_valid;
   logic              req_ready;
   logic [5:0]        req_op;
   logic [4:0]        req_rs, req_rt, req_rd, req_shamt;
   logic [5:0]        req_funct;
   logic [15:0]       req_imm;
   logic [25:0]       req_target;
   logic              req_last;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              busy, done, err, overflow;
   logic [ADDR_W:0]   count;

   always #5 clk = ~clk;

   mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
      .clk(clk), .rst(rst), .start(start),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
      .req_shamt(req_shamt), .req_funct(req_funct), .req_imm(req_imm),
      .req_target(req_target), .req_last(req_last),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .busy(busy), .done(done), .err(err), .overflow(overflow), .count(count)
   );

   typedef struct {
      int op, rs, rt, rd, sh, fn, imm, tgt;
      bit last;
   } req_t;

   typedef struct {
      int          cyc;
      int          addr;
      logic [31:0] data;
   } wr_t;

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   wr_t exp_q[$];
   wr_t mon_e;

   // Reference model state: words written since start plus the sticky flags.
   int  m_count;
   bit  m_err, m_ovf, m_done;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit is_legal(input int op);
      return op == 0 || op == 2 || op == 3 || op == 4 || op == 9 || op == 35 || op == 43;
   endfunction

   function automatic logic [31:0] ref_word(input req_t r);
      longint w;
      w = longint'(r.op) * (64'd1 << 26);
      if (r.op == 0)
         w += r.rs * (64'd1 << 21) + r.rt * (64'd1 << 16) + r.rd * (64'd1 << 11) + r.sh * 64 + r.fn;
      else if (r.op == 2 || r.op == 3)
         w += r.tgt;
      else
         w += r.rs * (64'd1 << 21) + r.rt * (64'd1 << 16) + r.imm;
      return 32'(w);
   endfunction

   function automatic req_t mk(input int op, rs, rt, rd, sh, fn, imm, tgt, input bit last);
      req_t r;
      r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.sh = sh;
      r.fn = fn; r.imm = imm; r.tgt = tgt; r.last = last;
      return r;
   endfunction

   function automatic req_t rand_req(input bit last);
      int ops[7] = '{0, 2, 3, 4, 9, 35, 43};
      int op;
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 6)];
      return mk(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                $urandom_range(0, 32'h3FFFFFF), last);
   endfunction

   task automatic apply(input req_t r);
      req_op     = 6'(r.op);
      req_rs     = 5'(r.rs);
      req_rt     = 5'(r.rt);
      req_rd     = 5'(r.rd);
      req_shamt  = 5'(r.sh);
      req_funct  = 6'(r.fn);
      req_imm    = 16'(r.imm);
      req_target = 26'(r.tgt);
      req_last   = r.last;
   endtask

   task automatic model_reset();
      m_count = 0; m_err = 0; m_ovf = 0; m_done = 0;
   endtask

   task automatic model_accept(input req_t r, input int wcyc);
      if (is_legal(r.op)) begin
         exp_q.push_back('{cyc: wcyc, addr: (BASE_ADDR + m_count) % DEPTH, data: ref_word(r)});
         m_count++;
         if (r.last) m_done = 1;
         else if (m_count == DEPTH) begin
            m_ovf  = 1;
            m_done = 1;
         end
      end else begin
         m_err = 1;
         if (r.last) m_done = 1;
      end
   endtask

   // Called just after a rising edge; returns just after the handshake edge.
   task automatic send(input req_t r);
      apply(r);
      req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready) begin
            model_accept(r, cyc + 1);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL handshake_timeout: req_ready stayed 0, expected 1 (cycle %0d)", cyc);
      req_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      model_reset();
   endtask

   task automatic end_checks(input string tag);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk({tag, "_done"}, done, m_done);
      chk({tag, "_busy"}, busy, !m_done);
      chk({tag, "_err"}, err, m_err);
      chk({tag, "_overflow"}, overflow, m_ovf);
      chk({tag, "_count"}, count, m_count);
      chk({tag, "_pending"}, exp_q.size(), 0);
      if (m_done) begin
         apply(rand_req(0));
         req_valid = 1'b1;
         @(negedge clk);
         chk({tag, "_ready_in_done"}, req_ready, 0);
         @(posedge clk);
         #1;
         req_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every write must match the oldest expectation in address, data and cycle.
   always @(negedge clk) begin
      if (!rst) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_write: no im_we for addr %0d, expected in cycle %0d (now %0d)",
                     exp_q[0].addr, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
         end
         if (im_we) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: im_we=1 addr %0d data 0x%0h, expected no write",
                        im_addr, im_wdata);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_cycle", cyc, mon_e.cyc);
               chk("wr_addr", im_addr, mon_e.addr);
               chk("wr_data", im_wdata, mon_e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      req_valid = 1'b0;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      model_reset();
      #12;
      chk("rst_ready", req_ready, 0);
      chk("rst_we", im_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_addr", im_addr, BASE_ADDR);
      chk("rst_wdata", im_wdata, 0);
      chk("rst_count", count, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // add $3,$1,$2
      do_start();
      send(mk(0, 1, 2, 3, 0, 32'h20, 0, 0, 0));
      end_checks("add");

      // lw, beq, j, jal back to back: fills the 4-word memory without req_last.
      do_start();
      send(mk(35, 29, 8, 0, 0, 0, 4, 0, 0));
      send(mk(4, 1, 2, 0, 0, 0, 32'hFFFF, 0, 0));
      send(mk(2, 0, 0, 0, 0, 0, 0, 32'h10, 0));
      send(mk(3, 0, 0, 0, 0, 0, 0, 32'h3FFFFFF, 0));
      @(negedge clk);
      chk("fill_ready_after_4th", req_ready, 0);
      end_checks("fill");

      // addiu, illegal opcode 63, then a legal final request.
      do_start();
      send(mk(9, 0, 1, 0, 0, 0, 5, 0, 0));
      send(mk(63, 1, 1, 1, 1, 1, 1, 1, 0));
      @(negedge clk);
      chk("illegal_err", err, 1);
      chk("illegal_count", count, 1);
      @(posedge clk);
      #1;
      send(mk(43, 3, 4, 0, 0, 0, 16, 0, 1));
      end_checks("illegal");

      // start while a write is in flight and req_valid is high.
      do_start();
      send(mk(0, 4, 5, 6, 7, 8, 0, 0, 0));
      start = 1'b1;
      apply(mk(9, 2, 2, 0, 0, 0, 7, 0, 0));
      req_valid = 1'b1;
      @(negedge clk);
      chk("start_blocks_ready", req_ready, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      req_valid = 1'b0;
      model_reset();
      @(negedge clk);
      chk("start_count_cleared", count, 0);
      chk("start_busy", busy, 1);
      @(posedge clk);
      #1;
      send(mk(35, 1, 2, 0, 0, 0, 8, 0, 1));
      end_checks("restart");

      // Asynchronous reset in the middle of a write.
      do_start();
      send(mk(4, 7, 7, 0, 0, 0, 3, 0, 0));
      #1;
      rst = 1'b1;
      #1;
      chk("arst_we", im_we, 0);
      chk("arst_ready", req_ready, 0);
      chk("arst_busy", busy, 0);
      chk("arst_addr", im_addr, BASE_ADDR);
      chk("arst_wdata", im_wdata, 0);
      chk("arst_count", count, 0);
      exp_q.delete();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      apply(mk(9, 1, 1, 0, 0, 0, 1, 0, 0));
      req_valid = 1'b1;
      @(negedge clk);
      chk("idle_ready", req_ready, 0);
      chk("idle_done", done, 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;

      // Randomized programs against the reference model.
      for (int p = 0; p < 60; p++) begin
         int n;
         do_start();
         n = $urandom_range(1, 7);
         for (int k = 0; k < n && !m_done; k++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            send(rand_req((k == n - 1) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0)));
         end
         end_checks("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Program-loading front end for the single-cycle MIPS core: accepts one instruction request per handshake (opcode plus register/immediate/target fields), validates the opcode against the set the control unit decodes, packs it into a 32-bit instruction word, and writes it to consecutive instruction-memory words. It is the encoding side of the opcode decoder, so every word it emits decodes to a defined control vector. It sits between the testbench or boot loader and the instruction-memory write port, and is idle while the CPU runs.

## Interface
- ADDR_W, 6, instruction-memory word-address width (depth 2^ADDR_W).
- BASE_ADDR, 0, first word address written after start.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; clears the counter and flags, then enters LOAD.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  6  MIPS opcode field.
- req_rs, req_rt, req_rd, req_shamt  in  5 each  register/shift fields.
- req_funct  in  6  R-format function field.
- req_imm  in  16  I-format immediate.
- req_target  in  26  J-format target.
- req_last  in  1  final instruction of the program.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  ADDR_W  word address.
- im_wdata  out  32  encoded instruction.
- busy  out  1  state is LOAD.
- done  out  1  state is DONE.
- err  out  1  sticky: an illegal opcode was rejected.
- overflow  out  1  sticky: memory filled before req_last.
- count  out  ADDR_W+1  words written since start.

## Operation
- States: IDLE, LOAD, DONE. Reset → IDLE. Any state with start=1 → LOAD, with count=0, err=0, overflow=0, and write pointer=BASE_ADDR.
- req_ready = (state==LOAD) && !start && (pointer not wrapped past the last word).
- Formats:
  - R, op 0: {op,rs,rt,rd,shamt,funct}.
  - I, ops 9 (ADDIU), 35 (LW), 43 (SW), 4 (BEQ): {op,rs,rt,imm}.
  - J, ops 2 (J), 3 (JAL): {op,target}.
  - Unused fields are ignored.
- Accepted legal opcode: the word is registered and written the next cycle; the pointer and count increment on the write.
- Accepted illegal opcode: no write; the pointer and count are unchanged; err is set.
- Accepted request with req_last=1, legal or not: after its write cycle (if any), LOAD → DONE.
- Write to address BASE_ADDR+2^ADDR_W-1 (last word) without req_last: overflow is set, req_ready drops, and the state goes to DONE.
- Pointer arithmetic is modulo 2^ADDR_W, so a nonzero BASE_ADDR wraps to 0. Capacity is always 2^ADDR_W words.
- DONE holds until start. req_valid is ignored in IDLE and DONE.

## Timing
- Reset values:
  - state IDLE.
  - req_ready, im_we, busy, done, err, overflow all 0.
  - im_addr = BASE_ADDR; im_wdata 0; count 0.
- Latency: handshake at cycle N → im_we=1 for exactly cycle N+1, with im_addr and im_wdata valid in that cycle. count updates at the end of N+1.
- Throughput: one request per cycle while req_ready=1. Back-to-back writes are allowed.
- start in the same cycle as req_valid: start wins and the request is not accepted.
- start while a write is in flight (handshake in the previous cycle): that write still completes at its old address. The counter reset takes priority, so count=0 afterwards.
- rst mid-write: im_we drops immediately (asynchronous).
- done/busy are registered state decodes, valid the cycle after the transition.

## Structure
- Shared package holds the opcode constants used by both decoder and encoder: R_FORMAT=0, J=2, JAL=3, BEQ=4, ADDIU=9, LW=35, SW=43. It also holds the state encoding.
- One natural sub-module, instr_pack: combinational format select and field concatenation, plus the legal-opcode flag.
- The top level holds the FSM, pointer/count, and output register.

## Test plan
- add $3,$1,$2 (op 0, rs 1, rt 2, rd 3, funct 0x20) → im_wdata 0x00221820 at im_addr 0, one cycle after the handshake.
- Back-to-back sequence:
  - lw (op 35, rs 29, rt 8, imm 4) → 0x8FA80004.
  - beq (op 4, rs 1, rt 2, imm 0xFFFF) → 0x1022FFFF.
  - j (op 2, target 0x10) → 0x08000010.
  - jal (op 3, target 0x3FFFFFF) → 0x0FFFFFFF.
  - Required response: addresses 0–3, count 4.
- addiu (op 9, rs 0, rt 1, imm 5) → 0x24010005. Then op 63 → err=1, no im_we, count unchanged. Then a legal request with req_last → written at the next address, done=1.
- ADDR_W=2: five requests without req_last → writes at 0..3, overflow=1, req_ready=0 after the 4th handshake, 5th not accepted, done=1.
- start pulsed mid-load with req_valid high → request not accepted, the in-flight write completes, count=0 next cycle, next write at BASE_ADDR.
- rst asserted asynchronously during LOAD → all outputs at their reset values before the next clock edge.
